apb_master_arb: RTL and testbench
=================================

# apb_master_arb

Two-port APB master that shares a single APB bus among two requesters (CPU load/store port = port 0, DMA port = port 1) and drives up to NUM_SLV APB slaves, such as the 4-register peripheral and the small RAM slave. It performs round-robin arbitration, address decode into one-hot PSEL, and the APB SETUP/ACCESS sequencing. It waits on the selected slave's PREADY, bounded by a timeout, and returns read data and an error flag to the granted requester.

## Interface
- NUM_SLV, 4: number of APB slaves, 1..16.
- TIMEOUT, 15: max ACCESS cycles without PREADY before abort, 1..255.

- PCLK  in  1  system clock; all logic on the rising edge.
- PRESET  in  1  reset; asynchronous, active-low.
- req0_valid / req1_valid  in  1  request pending; held with stable fields until that port's done.
- req0_write / req1_write  in  1  1 = write, 0 = read.
- req0_addr / req1_addr  in  32  byte address.
- req0_wdata / req1_wdata  in  32  write data.
- req0_done / req1_done  out  1  one-cycle completion pulse.
- req0_rdata / req1_rdata  out  32  read data; valid while done is high; 0 for writes and errors.
- req0_err / req1_err  out  1  valid while done is high; 1 = decode error or timeout.
- PADDR  out  32  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PENABLE  out  1  APB enable.
- PSEL  out  NUM_SLV  one-hot slave select.
- PRDATA  in  32*NUM_SLV  concatenated slave read data; slave i occupies [32i+31:32i].
- PREADY  in  NUM_SLV  per-slave ready.

## Operation
- Decode: address is valid iff addr[31:16] == 16'h1000 and addr[15:12] < NUM_SLV. The slave index is addr[15:12]. The slave sees the full address on PADDR and uses the low bits (PADDR[3:2]) for its word offset.
- Arbitration, evaluated only in IDLE:
  - If exactly one valid is high, that port wins.
  - If both are high, the port not granted last wins.
  - The last-grant pointer updates on every grant and resets to 1, so port 0 wins the first tie.
- FSM states: IDLE, SETUP, ACCESS, DONE.
  - IDLE: PSEL=0, PENABLE=0. On a grant with a valid address, latch port, index, write, addr and wdata, drive PADDR/PWRITE/PWDATA, and go to SETUP. On a grant with an invalid address, go straight to DONE with err=1 and no APB activity.
  - SETUP: PSEL[idx]=1, PENABLE=0. Always go to ACCESS next.
  - ACCESS: PSEL[idx]=1, PENABLE=1.
    - If PREADY[idx]=1: capture PRDATA slice idx (reads only), err=0, go to DONE.
    - Otherwise increment the wait counter. When the counter reaches TIMEOUT, set err=1 and go to DONE.
  - DONE: PSEL=0, PENABLE=0. Pulse reqN_done for the granted port only, with registered rdata/err. Go to IDLE.
- PREADY of non-selected slaves is ignored.
- PADDR/PWRITE/PWDATA hold their last values outside transfers.
- Dropping valid mid-transfer is ignored: the transfer completes and done still pulses.
- Requesters must sample done and drop or change valid by the next edge. IDLE then re-arbitrates one cycle after DONE, so a completed request is never regranted.

## Timing
- Reset (async assert, sync release):
  - State IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
  - All done=0, rdata=0, err=0.
  - Wait counter 0; pointer=1.
- Transfer latency:
  - With valid seen in IDLE at edge 0: SETUP after edge 1, ACCESS after edge 2.
  - With PREADY high in the first ACCESS cycle: DONE after edge 3, done visible for that cycle.
  - Each PREADY wait cycle adds 1.
- Decode error: done with err=1 after edge 1.
- Timeout: ACCESS lasts exactly TIMEOUT cycles, then DONE.
- Back-to-back: a new grant is possible at the first IDLE cycle, so a zero-wait transfer occupies 4 cycles.
- Reset asserted mid-transfer: PSEL/PENABLE drop immediately (asynchronously) and no done is produced.

## Test plan
- Write port0 addr 0x1000_1004, data 0xDEADBEEF, to slave 1, where slave 1 raises PREADY one cycle into ACCESS -> PSEL=4'b0010, PENABLE high for 2 cycles, req0_done pulses with err=0; a following read of 0x1000_1004 returns req0_rdata=0xDEADBEEF.
- Both valid in the same cycle from reset, each reading a different slave -> port 0 is served first, then port 1; with both held continuously, grants alternate 0,1,0,1.
- Read of 0x2000_0000, and separately 0x1000_4000 with NUM_SLV=4 -> no PSEL activity; done with err=1, rdata=0 one cycle after grant.
- Slave never raises PREADY, TIMEOUT=15 -> PENABLE high for exactly 15 cycles; done with err=1; the bus is then released and the next request is served.
- PRESET pulsed low during ACCESS -> PSEL=0 and PENABLE=0 immediately, no done; after release a new request completes normally.

Source files
------------

// File: rtl/apb_master_arb_if.sv
// apb_master_arb_if
//   Bundles the two requester ports and the shared APB bus of apb_master_arb.
//   Ports (all signals, grouped):
//     req0_*/req1_*  : requester handshake (valid/write/addr/wdata in, done/rdata/err out)
//     PADDR/PWRITE/PWDATA/PENABLE/PSEL : APB master outputs
//     PRDATA/PREADY  : per-slave APB returns, slave i at PRDATA[32i+31:32i]
//   modport master : the arbiter side
//   modport slave  : the requester/peripheral side
interface apb_master_arb_if #(
    parameter int NUM_SLV = 4
);
    logic                     req0_valid;
    logic                     req0_write;
    logic [31:0]              req0_addr;
    logic [31:0]              req0_wdata;
    logic                     req0_done;
    logic [31:0]              req0_rdata;
    logic                     req0_err;

    logic                     req1_valid;
    logic                     req1_write;
    logic [31:0]              req1_addr;
    logic [31:0]              req1_wdata;
    logic                     req1_done;
    logic [31:0]              req1_rdata;
    logic                     req1_err;

    logic [31:0]              PADDR;
    logic                     PWRITE;
    logic [31:0]              PWDATA;
    logic                     PENABLE;
    logic [NUM_SLV-1:0]       PSEL;
    logic [32*NUM_SLV-1:0]    PRDATA;
    logic [NUM_SLV-1:0]       PREADY;

    modport master (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_done, req0_rdata, req0_err,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_done, req1_rdata, req1_err,
        output PADDR, PWRITE, PWDATA, PENABLE, PSEL,
        input  PRDATA, PREADY
    );

    modport slave (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_done, req0_rdata, req0_err,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_done, req1_rdata, req1_err,
        input  PADDR, PWRITE, PWDATA, PENABLE, PSEL,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_master_arb.sv
// apb_master_arb
//   Two-port APB master: round-robin arbitration between port 0 (CPU) and
//   port 1 (DMA), address decode into one-hot PSEL, SETUP/ACCESS sequencing
//   with a bounded PREADY wait, and a one-cycle done pulse back to the winner.
//   Ports:
//     PCLK    : clock, rising edge
//     PRESET  : asynchronous active-low reset
//     bus     : apb_master_arb_if.master (requesters + APB bus)
//
//   state  | meaning
//   IDLE   | bus idle, arbitrate and decode on any valid
//   SETUP  | PSEL asserted, PENABLE low
//   ACCESS | PSEL+PENABLE, wait for PREADY or timeout
//   DONE   | done pulse to the granted port with registered rdata/err
module apb_master_arb #(
    parameter int NUM_SLV = 4,
    parameter int TIMEOUT = 15
) (
    input logic               PCLK,
    input logic               PRESET,
    apb_master_arb_if.master  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_DONE} state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_last;
    logic         r_port;
    logic [3:0]   r_idx;
    logic [31:0]  r_paddr;
    logic [31:0]  r_pwdata;
    logic         r_pwrite;
    logic [31:0]  r_rdata;
    logic         r_err;
    logic [7:0]   r_wait;

    logic         w_any;
    logic         w_gnt;
    logic         w_grant;
    logic         w_write;
    logic [31:0]  w_addr;
    logic [31:0]  w_wdata;
    logic         w_dec_ok;
    logic         w_pready;
    logic [31:0]  w_prdata;
    logic         w_timeout;
    logic [NUM_SLV-1:0] w_psel;
    logic         w_penable;
    logic         w_done0;
    logic         w_done1;

    // On a tie the port that did not win last time is chosen.
    assign w_any    = bus.req0_valid | bus.req1_valid;
    assign w_gnt    = (bus.req0_valid && bus.req1_valid) ? ~r_last : bus.req1_valid;
    assign w_write  = w_gnt ? bus.req1_write : bus.req0_write;
    assign w_addr   = w_gnt ? bus.req1_addr  : bus.req0_addr;
    assign w_wdata  = w_gnt ? bus.req1_wdata : bus.req0_wdata;
    assign w_dec_ok = (w_addr[31:16] == 16'h1000) &&
                      ({1'b0, w_addr[15:12]} < 5'(NUM_SLV));

    // r_wait counts completed ACCESS cycles, so ACCESS lasts exactly TIMEOUT cycles.
    assign w_timeout = (r_wait + 8'd1) == 8'(TIMEOUT);

    always_comb begin
        w_pready = 1'b0;
        w_prdata = '0;
        w_psel   = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (r_idx == 4'(i)) begin
                w_pready = bus.PREADY[i];
                w_prdata = bus.PRDATA[32*i +: 32];
                w_psel[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_penable   = 1'b0;
        bus.PSEL    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = w_dec_ok ? ST_SETUP : ST_DONE;
                end
            end
            ST_SETUP: begin
                bus.PSEL    = w_psel;
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                bus.PSEL  = w_psel;
                w_penable = 1'b1;
                if (w_pready || w_timeout) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_last   <= 1'b1;
            r_port   <= 1'b0;
            r_idx    <= '0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pwrite <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_wait   <= '0;
        end else begin
            if (w_grant) begin
                r_last  <= w_gnt;
                r_port  <= w_gnt;
                r_rdata <= '0;
                r_err   <= ~w_dec_ok;
                r_wait  <= '0;
                // Bus fields are only updated for real transfers so they hold otherwise.
                if (w_dec_ok) begin
                    r_idx    <= w_addr[15:12];
                    r_paddr  <= w_addr;
                    r_pwrite <= w_write;
                    r_pwdata <= w_wdata;
                end
            end
            if (r_state == ST_ACCESS) begin
                if (w_pready) begin
                    r_rdata <= r_pwrite ? 32'h0 : w_prdata;
                    r_err   <= 1'b0;
                end else begin
                    r_wait <= r_wait + 8'd1;
                    if (w_timeout) r_err <= 1'b1;
                end
            end
        end
    end

    assign w_done0 = (r_state == ST_DONE) && !r_port;
    assign w_done1 = (r_state == ST_DONE) &&  r_port;

    assign bus.PENABLE    = w_penable;
    assign bus.PADDR      = r_paddr;
    assign bus.PWRITE     = r_pwrite;
    assign bus.PWDATA     = r_pwdata;
    assign bus.req0_done  = w_done0;
    assign bus.req1_done  = w_done1;
    assign bus.req0_rdata = w_done0 ? r_rdata : 32'h0;
    assign bus.req1_rdata = w_done1 ? r_rdata : 32'h0;
    assign bus.req0_err   = w_done0 & r_err;
    assign bus.req1_err   = w_done1 & r_err;
endmodule

// File: tb/tb_apb_master_arb.sv
// tb_apb_master_arb
//   Bench for apb_master_arb with NUM_SLV=4, TIMEOUT=15. Behavioural APB
//   slaves (4 words each, programmable wait/hang, noisy PREADY/PRDATA on
//   unselected slaves) and a transaction-level reference memory.
module tb_apb_master_arb;
    localparam int NUM_SLV = 4;
    localparam int TIMEOUT = 15;

    logic PCLK = 1'b0;
    logic PRESET;
    always #5 PCLK = ~PCLK;

    apb_master_arb_if #(.NUM_SLV(NUM_SLV)) bus();

    apb_master_arb #(.NUM_SLV(NUM_SLV), .TIMEOUT(TIMEOUT)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus.master)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- slave models ----------------
    logic [31:0]        slv_mem [NUM_SLV][4];
    bit                 slv_hang [NUM_SLV];
    int                 slv_wait [NUM_SLV];
    logic [NUM_SLV-1:0] noise_rdy = '0;
    logic [31:0]        junk = 32'h0;
    int                 acc_cnt;

    always @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) acc_cnt <= 0;
        else         acc_cnt <= bus.PENABLE ? acc_cnt + 1 : 0;
    end

    always_comb begin
        bus.PREADY = '0;
        bus.PRDATA = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (bus.PSEL[i] && bus.PENABLE)
                bus.PREADY[i] = !slv_hang[i] && (acc_cnt >= slv_wait[i]);
            else
                bus.PREADY[i] = noise_rdy[i];
            bus.PRDATA[32*i +: 32] = bus.PSEL[i] ? slv_mem[i][bus.PADDR[3:2]] : (junk ^ 32'(i));
        end
    end

    always @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            for (int i = 0; i < NUM_SLV; i++)
                for (int j = 0; j < 4; j++)
                    slv_mem[i][j] <= 32'hA5A5_0000 + 32'(i * 16 + j);
        end else begin
            for (int i = 0; i < NUM_SLV; i++)
                if (bus.PSEL[i] && bus.PENABLE && bus.PREADY[i] && bus.PWRITE)
                    slv_mem[i][bus.PADDR[3:2]] <= bus.PWDATA;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [int];

    function automatic logic [31:0] ref_read(input int idx, input int off);
        int key = idx * 4 + off;
        if (ref_mem.exists(key)) return ref_mem[key];
        return 32'hA5A5_0000 + 32'(idx * 16 + off);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int port, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            bus.req0_valid = 1'b1; bus.req0_write = wr; bus.req0_addr = addr; bus.req0_wdata = wdata;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_write = wr; bus.req1_addr = addr; bus.req1_wdata = wdata;
        end
    endtask

    task automatic clear_req(input int port);
        if (port == 0) bus.req0_valid = 1'b0;
        else           bus.req1_valid = 1'b0;
    endtask

    task automatic apply_reset();
        PRESET = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_write = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_write = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin slv_hang[i] = 1'b0; slv_wait[i] = 0; end
        ref_mem.delete();
        repeat (3) @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
    endtask

    // One request from one port; starts and ends at a negedge with the master idle.
    task automatic do_req(input int port, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int wt, input bit hang, input string tag);
        bit ok, got, psel_bad, other_done, exp_err;
        int idx, off, exp_lat, exp_pen, lat, pen;
        logic [31:0] exp_rd, obs_rd, paddr_seen, pwdata_seen;
        logic obs_err, pwrite_seen;
        logic [NUM_SLV-1:0] psel_seen, exp_psel;
        ok  = (addr[31:16] == 16'h1000) && (int'(addr[15:12]) < NUM_SLV);
        idx = int'(addr[15:12]);
        off = int'(addr[3:2]);
        if (ok) begin slv_wait[idx] = wt; slv_hang[idx] = hang; end
        noise_rdy = NUM_SLV'($urandom);
        junk      = $urandom;
        exp_lat  = !ok ? 1 : (hang ? 2 + TIMEOUT : 3 + wt);
        exp_pen  = !ok ? 0 : (hang ? TIMEOUT : wt + 1);
        exp_err  = !ok || hang;
        exp_rd   = (!exp_err && !wr) ? ref_read(idx, off) : 32'h0;
        exp_psel = ok ? NUM_SLV'(1 << idx) : '0;
        got = 0; psel_bad = 0; other_done = 0; lat = 0; pen = 0;
        psel_seen = '0; paddr_seen = '0; pwdata_seen = '0; pwrite_seen = 1'b0;
        obs_rd = '0; obs_err = 1'b0;
        set_req(port, wr, addr, wdata);
        for (int c = 0; c < 60 && !got; c++) begin
            @(posedge PCLK);
            lat++;
            @(negedge PCLK);
            if (bus.PENABLE) pen++;
            if (bus.PSEL != '0) begin
                if (psel_seen != '0 && psel_seen != bus.PSEL) psel_bad = 1;
                psel_seen   = bus.PSEL;
                paddr_seen  = bus.PADDR;
                pwrite_seen = bus.PWRITE;
                pwdata_seen = bus.PWDATA;
            end
            if (port == 0) begin
                if (bus.req1_done) other_done = 1;
                if (bus.req0_done) begin got = 1; obs_rd = bus.req0_rdata; obs_err = bus.req0_err; end
            end else begin
                if (bus.req0_done) other_done = 1;
                if (bus.req1_done) begin got = 1; obs_rd = bus.req1_rdata; obs_err = bus.req1_err; end
            end
        end
        check_val({tag, "_done"}, 64'(got), 64'd1);
        if (got) begin
            check_val({tag, "_lat"},   64'(lat), 64'(exp_lat));
            check_val({tag, "_err"},   64'(obs_err), 64'(exp_err));
            check_val({tag, "_rdata"}, 64'(obs_rd), 64'(exp_rd));
        end
        check_val({tag, "_pen"},  64'(pen), 64'(exp_pen));
        check_val({tag, "_psel"}, psel_bad ? 64'hFF : 64'(psel_seen), 64'(exp_psel));
        check_val({tag, "_other_done"}, 64'(other_done), 64'd0);
        if (ok) begin
            check_val({tag, "_paddr"},  64'(paddr_seen), 64'(addr));
            check_val({tag, "_pwrite"}, 64'(pwrite_seen), 64'(wr));
            if (wr) check_val({tag, "_pwdata"}, 64'(pwdata_seen), 64'(wdata));
            if (wr && !hang) ref_mem[idx * 4 + off] = wdata;
            slv_hang[idx] = 1'b0;
        end
        clear_req(port);
        @(negedge PCLK);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int order [$];
        int done_cyc [$];
        bit both_done, reached;
        logic [3:0] order_bits;
        int cyc;
        logic seen_done;

        PRESET = 1'b1;
        #2;
        apply_reset();
        check_val("rst_psel",    64'(bus.PSEL), 64'd0);
        check_val("rst_penable", 64'(bus.PENABLE), 64'd0);
        check_val("rst_pwrite",  64'(bus.PWRITE), 64'd0);
        check_val("rst_paddr",   64'(bus.PADDR), 64'd0);
        check_val("rst_pwdata",  64'(bus.PWDATA), 64'd0);
        check_val("rst_done",    64'({bus.req0_done, bus.req1_done}), 64'd0);
        check_val("rst_err",     64'({bus.req0_err, bus.req1_err}), 64'd0);
        check_val("rst_rdata",   64'({bus.req0_rdata, bus.req1_rdata}), 64'd0);

        // Tie from reset: port 0 first, then strict alternation, 4 cycles apart.
        set_req(0, 1'b0, 32'h1000_0000, 32'h0);
        set_req(1, 1'b0, 32'h1000_2004, 32'h0);
        both_done = 0; cyc = 0;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            @(posedge PCLK);
            cyc++;
            @(negedge PCLK);
            if (bus.req0_done && bus.req1_done) both_done = 1;
            if (bus.req0_done) begin
                order.push_back(0); done_cyc.push_back(cyc);
                check_val("tie_rdata0", 64'(bus.req0_rdata), 64'(ref_read(0, 0)));
            end else if (bus.req1_done) begin
                order.push_back(1); done_cyc.push_back(cyc);
                check_val("tie_rdata1", 64'(bus.req1_rdata), 64'(ref_read(2, 1)));
            end
        end
        clear_req(0);
        clear_req(1);
        @(negedge PCLK);
        check_val("tie_count", 64'(order.size()), 64'd4);
        check_val("tie_both",  64'(both_done), 64'd0);
        order_bits = '0;
        for (int k = 0; k < order.size() && k < 4; k++) order_bits[k] = order[k][0];
        check_val("tie_order", 64'(order_bits), 64'b1010);
        if (done_cyc.size() == 4) begin
            check_val("tie_first_lat", 64'(done_cyc[0]), 64'd3);
            for (int k = 1; k < 4; k++)
                check_val("tie_spacing", 64'(done_cyc[k] - done_cyc[k-1]), 64'd4);
        end

        // Write then read back on slave 1 with one wait cycle.
        do_req(0, 1'b1, 32'h1000_1004, 32'hDEAD_BEEF, 1, 1'b0, "wr_s1");
        do_req(0, 1'b0, 32'h1000_1004, 32'h0,         1, 1'b0, "rd_s1");

        // Decode errors.
        do_req(0, 1'b0, 32'h2000_0000, 32'h0, 0, 1'b0, "dec_hi");
        do_req(1, 1'b0, 32'h1000_4000, 32'h0, 0, 1'b0, "dec_idx");

        // Timeout then the bus is usable again.
        do_req(0, 1'b0, 32'h1000_3000, 32'h0,         0, 1'b1, "tmo");
        do_req(1, 1'b1, 32'h1000_3008, 32'h1234_5678, 0, 1'b0, "post_tmo_wr");
        do_req(0, 1'b0, 32'h1000_3008, 32'h0,         2, 1'b0, "post_tmo_rd");

        // Reset during ACCESS.
        slv_wait[2] = 0;
        slv_hang[2] = 1'b1;
        set_req(1, 1'b0, 32'h1000_2008, 32'h0);
        reached = 0;
        for (int c = 0; c < 10 && !reached; c++) begin
            @(negedge PCLK);
            if (bus.PENABLE) reached = 1;
        end
        check_val("mid_rst_access", 64'(reached), 64'd1);
        @(negedge PCLK);
        #2 PRESET = 1'b0;
        #1;
        check_val("mid_rst_psel",    64'(bus.PSEL), 64'd0);
        check_val("mid_rst_penable", 64'(bus.PENABLE), 64'd0);
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge PCLK);
            seen_done = seen_done | bus.req0_done | bus.req1_done;
        end
        check_val("mid_rst_nodone", 64'(seen_done), 64'd0);
        clear_req(1);
        slv_hang[2] = 1'b0;
        ref_mem.delete();
        PRESET = 1'b1;
        @(negedge PCLK);
        do_req(1, 1'b0, 32'h1000_2008, 32'h0, 0, 1'b0, "post_rst_rd");

        // Randomized single-port traffic.
        for (int n = 0; n < 40; n++) begin
            int port, sel, wt;
            bit wr, hang;
            logic [31:0] addr;
            port = $urandom_range(0, 1);
            wr   = 1'($urandom_range(0, 1));
            sel  = $urandom_range(0, 9);
            wt   = $urandom_range(0, 3);
            hang = ($urandom_range(0, 11) == 0);
            if (sel == 0)
                addr = {16'(16'h2000 + $urandom_range(0, 255)), 16'($urandom)} & 32'hFFFF_FFFC;
            else if (sel == 1)
                addr = 32'h1000_0000 | (32'($urandom_range(4, 15)) << 12) | (32'($urandom_range(0, 3)) << 2);
            else
                addr = 32'h1000_0000 | (32'($urandom_range(0, NUM_SLV - 1)) << 12)
                     | (32'($urandom_range(0, 255)) << 4) | (32'($urandom_range(0, 3)) << 2);
            do_req(port, wr, addr, $urandom, wt, hang, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
